ascensor_ctrl_n: RTL and testbench
==================================

ASCENSOR_CTRL_N -- requirements
Module: ascensor_ctrl_n

Interface
REQ-001 Parameter NUM_PISOS, default 10, number of floors served (2..64).
REQ-002 Parameter T_PUERTA, default 50, door dwell time in clk cycles.
REQ-003 Parameter T_VIAJE, default 1000, max cycles between floor pulses while moving.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 botones  in  NUM_PISOS  floor call buttons, level, bit i = floor i.
REQ-007 boton_puertas  in  2  [0] open-door request, [1] close-door request.
REQ-008 estado_puertas  in  2  [0] doors fully open, [1] doors fully closed.
REQ-009 cambio_piso  in  1  one-cycle pulse on arrival at the next floor.
REQ-010 sensor_puertas  in  1  door obstruction, high = blocked.
REQ-011 luces  out  NUM_PISOS  latched pending calls.
REQ-012 display  out  $clog2(NUM_PISOS)  current floor, binary.
REQ-013 aviso  out  4  [0] moving up, [1] moving down, [2] obstruction, [3] fault.
REQ-014 puertas  out  2  01 open command, 10 close command, 00 idle; 11 never driven.
REQ-015 motor  out  2  01 up, 10 down, 00 stop; 11 never driven.

Function
REQ-016 FSM states: REPOSO, SUBIENDO, BAJANDO, ABRIENDO, ABIERTA, CERRANDO, FALLA.
REQ-017 Any botones bit high sets the matching luces bit next cycle; bit held until serviced.
REQ-018 luces bit for current floor clears on the cycle ABIERTA is entered.
REQ-019 REPOSO: call at current floor or boton_puertas[0] -> ABRIENDO; else calls above -> SUBIENDO; else calls below -> BAJANDO; above and below both pending -> SUBIENDO.
REQ-020 SUBIENDO drives motor=01, aviso[0]=1; BAJANDO drives motor=10, aviso[1]=1.
REQ-021 cambio_piso in SUBIENDO/BAJANDO increments/decrements display by 1, saturating at NUM_PISOS-1 / 0.
REQ-022 After floor update, pending call at new floor, or floor 0/NUM_PISOS-1 reached -> motor=00 same cycle as state change to ABRIENDO.
REQ-023 cambio_piso outside SUBIENDO/BAJANDO is ignored.
REQ-024 ABRIENDO drives puertas=01 until estado_puertas[0]=1, then ABIERTA.
REQ-025 ABIERTA drives puertas=00; dwell counter loads T_PUERTA on entry, decrements per cycle, at 0 -> CERRANDO.
REQ-026 In ABIERTA, sensor_puertas or boton_puertas[0] reloads dwell counter; boton_puertas[1] with no obstruction -> CERRANDO next cycle; both buttons high -> open wins.
REQ-027 CERRANDO drives puertas=10 until estado_puertas[1]=1; sensor_puertas or boton_puertas[0] during CERRANDO -> ABRIENDO next cycle.
REQ-028 Door closed: continue previous direction if calls remain that way, else reverse if calls opposite, else REPOSO.
REQ-029 aviso[2] mirrors sensor_puertas registered, one-cycle latency, in all states.
REQ-030 Watchdog loads T_VIAJE on entering SUBIENDO/BAJANDO and on each cambio_piso; expiry -> FALLA.
REQ-031 FALLA: motor=00, puertas=00, aviso[3]=1, inputs ignored; exit only by reset.
REQ-032 motor nonzero only when estado_puertas[1]=1; otherwise FSM holds in REPOSO with motor=00.

Reset
REQ-033 reset low asynchronously forces REPOSO, luces=0, display=0, aviso=0, puertas=00, motor=00, counters 0.
REQ-034 reset asserted mid-travel or mid-door-cycle aborts the operation; pending calls are lost.
REQ-035 First state change occurs no earlier than the second posedge after reset deasserts.

Structure
REQ-036 Package ascensor_pkg holds the state enum and motor/puertas encodings (MOTOR_SUBE, MOTOR_BAJA, MOTOR_PARA, PUERTA_ABRE, PUERTA_CIERRA).
REQ-037 Dwell and watchdog counters use one sub-module, temporizador, parametrised width, load/enable/zero flag.

Verification
REQ-038 Reset, display=0, botones[3] pulse -> luces[3]=1, motor=01, three cambio_piso -> display=3, motor=00, puertas=01.
REQ-039 At floor 5 idle, botones[8] and botones[2] same cycle -> goes up first, services 8, then down to 2; luces clear at each door-open.
REQ-040 ABIERTA, sensor_puertas high 100 cycles -> doors stay open, aviso[2]=1; release -> CERRANDO after T_PUERTA cycles.
REQ-041 CERRANDO, sensor_puertas pulse -> puertas=01 next cycle, returns to ABIERTA.
REQ-042 SUBIENDO, no cambio_piso for T_VIAJE cycles -> motor=00, aviso[3]=1; held until reset.
REQ-043 NUM_PISOS=4 build: call floor 3 from 0 -> display saturates at 3, motor stops, no wrap.

Source files
------------

// File: rtl/ascensor_pkg.sv
// Shared state encoding and actuator command codes for the elevator controller.
package ascensor_pkg;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        SUBIENDO = 3'd1,
        BAJANDO  = 3'd2,
        ABRIENDO = 3'd3,
        ABIERTA  = 3'd4,
        CERRANDO = 3'd5,
        FALLA    = 3'd6
    } estado_t;

    localparam logic [1:0] MOTOR_PARA    = 2'b00;
    localparam logic [1:0] MOTOR_SUBE    = 2'b01;
    localparam logic [1:0] MOTOR_BAJA    = 2'b10;

    localparam logic [1:0] PUERTA_NADA   = 2'b00;
    localparam logic [1:0] PUERTA_ABRE   = 2'b01;
    localparam logic [1:0] PUERTA_CIERRA = 2'b10;

endpackage

// File: rtl/ascensor_ctrl_n_temporizador.sv
// Down-counter with load priority over enable; stops at zero and flags it.
module temporizador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         carga,
    input  logic         habilita,
    input  logic [W-1:0] valor,
    output logic         cero
);

    logic [W-1:0] cuenta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= valor;
        end else if (habilita && cuenta != '0) begin
            cuenta <= cuenta - W'(1);
        end
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/ascensor_ctrl_n.sv
// Single-car elevator controller: call latching, travel, door cycle and travel watchdog.
// The FSM state is exported on `estado` for observation.
module ascensor_ctrl_n
    import ascensor_pkg::*;
#(
    parameter int NUM_PISOS = 10,
    parameter int T_PUERTA  = 50,
    parameter int T_VIAJE   = 1000,
    localparam int WD       = $clog2(NUM_PISOS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PISOS-1:0] botones,
    input  logic [1:0]           boton_puertas,
    input  logic [1:0]           estado_puertas,
    input  logic                 cambio_piso,
    input  logic                 sensor_puertas,
    output logic [NUM_PISOS-1:0] luces,
    output logic [WD-1:0]        display,
    output logic [3:0]           aviso,
    output logic [1:0]           puertas,
    output logic [1:0]           motor,
    output estado_t              estado
);

    localparam int            WP        = $clog2(T_PUERTA + 1);
    localparam int            WV        = $clog2(T_VIAJE + 1);
    localparam logic [WD-1:0] PISO_TOPE = WD'(NUM_PISOS - 1);

    logic          arm, sube_r, obst_r, falla_r;
    logic          hay_arriba, hay_abajo, hay_aqui, parar, pide_abrir;
    logic [WD-1:0] piso_sig;
    logic          dw_carga, dw_cero, wd_carga, wd_cero, en_marcha;

    assign en_marcha  = (estado == SUBIENDO) || (estado == BAJANDO);
    assign pide_abrir = sensor_puertas || boton_puertas[0];

    // Both timers sit preloaded outside their active state, so entry always sees a full count.
    assign dw_carga = (estado != ABIERTA) || pide_abrir;
    assign wd_carga = !en_marcha || cambio_piso;

    temporizador #(.W(WP)) u_dwell (
        .clk(clk), .reset(reset), .carga(dw_carga), .habilita(1'b1),
        .valor(WP'(T_PUERTA)), .cero(dw_cero)
    );

    temporizador #(.W(WV)) u_watchdog (
        .clk(clk), .reset(reset), .carga(wd_carga), .habilita(1'b1),
        .valor(WV'(T_VIAJE)), .cero(wd_cero)
    );

    always_comb begin
        hay_arriba = 1'b0;
        hay_abajo  = 1'b0;
        for (int i = 0; i < NUM_PISOS; i++) begin
            if (luces[i] && i > int'(display)) hay_arriba = 1'b1;
            if (luces[i] && i < int'(display)) hay_abajo  = 1'b1;
        end
    end

    assign hay_aqui = luces[display];

    always_comb begin
        piso_sig = display;
        if (estado == SUBIENDO && display != PISO_TOPE)   piso_sig = display + WD'(1);
        else if (estado == BAJANDO && display != '0)      piso_sig = display - WD'(1);
    end

    assign parar = luces[piso_sig] || (piso_sig == '0) || (piso_sig == PISO_TOPE);
    assign aviso = {falla_r, obst_r, motor};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado  <= REPOSO;
            luces   <= '0;
            display <= '0;
            motor   <= MOTOR_PARA;
            puertas <= PUERTA_NADA;
            sube_r  <= 1'b1;
            obst_r  <= 1'b0;
            falla_r <= 1'b0;
            arm     <= 1'b0;
        end else begin
            arm    <= 1'b1;
            obst_r <= sensor_puertas;
            if (estado != FALLA) luces <= luces | botones;
            // The FSM stays quiet for the first edge after reset release.
            if (arm) begin
                case (estado)
                    REPOSO: begin
                        motor   <= MOTOR_PARA;
                        puertas <= PUERTA_NADA;
                        if (hay_aqui || boton_puertas[0]) begin
                            estado  <= ABRIENDO;
                            puertas <= PUERTA_ABRE;
                        end else if (estado_puertas[1] && hay_arriba) begin
                            estado <= SUBIENDO;
                            motor  <= MOTOR_SUBE;
                            sube_r <= 1'b1;
                        end else if (estado_puertas[1] && hay_abajo) begin
                            estado <= BAJANDO;
                            motor  <= MOTOR_BAJA;
                            sube_r <= 1'b0;
                        end
                    end
                    SUBIENDO, BAJANDO: begin
                        if (!estado_puertas[1]) begin
                            estado <= REPOSO;
                            motor  <= MOTOR_PARA;
                        end else if (cambio_piso) begin
                            display <= piso_sig;
                            if (parar) begin
                                estado  <= ABRIENDO;
                                motor   <= MOTOR_PARA;
                                puertas <= PUERTA_ABRE;
                            end
                        end else if (wd_cero) begin
                            estado  <= FALLA;
                            motor   <= MOTOR_PARA;
                            falla_r <= 1'b1;
                        end
                    end
                    ABRIENDO: begin
                        puertas <= PUERTA_ABRE;
                        if (estado_puertas[0]) begin
                            estado         <= ABIERTA;
                            puertas        <= PUERTA_NADA;
                            luces[display] <= 1'b0;
                        end
                    end
                    ABIERTA: begin
                        puertas <= PUERTA_NADA;
                        if (!pide_abrir && (boton_puertas[1] || dw_cero)) begin
                            estado  <= CERRANDO;
                            puertas <= PUERTA_CIERRA;
                        end
                    end
                    CERRANDO: begin
                        if (pide_abrir) begin
                            estado  <= ABRIENDO;
                            puertas <= PUERTA_ABRE;
                        end else if (estado_puertas[1]) begin
                            puertas <= PUERTA_NADA;
                            if (sube_r ? hay_arriba : hay_abajo) begin
                                estado <= sube_r ? SUBIENDO : BAJANDO;
                                motor  <= sube_r ? MOTOR_SUBE : MOTOR_BAJA;
                            end else if (sube_r ? hay_abajo : hay_arriba) begin
                                estado <= sube_r ? BAJANDO : SUBIENDO;
                                motor  <= sube_r ? MOTOR_BAJA : MOTOR_SUBE;
                                sube_r <= !sube_r;
                            end else begin
                                estado <= REPOSO;
                            end
                        end
                    end
                    FALLA: begin
                        motor   <= MOTOR_PARA;
                        puertas <= PUERTA_NADA;
                    end
                    default: estado <= REPOSO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ascensor_ctrl_n.sv
// Directed bench: a 10-floor controller for travel/door/fault scenarios and a 4-floor one for the top-floor stop.
module tb_ascensor_ctrl_n;
    import ascensor_pkg::*;

    localparam int TP = 8;
    localparam int TV = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [9:0] botones_a, luces_a;
    logic [1:0] bp_a, ep_a, puertas_a, motor_a;
    logic       cp_a, sp_a;
    logic [3:0] display_a, aviso_a;
    estado_t    estado_a;

    logic [3:0] botones_b, luces_b;
    logic [1:0] bp_b, ep_b, puertas_b, motor_b, display_b;
    logic       cp_b, sp_b;
    logic [3:0] aviso_b;
    estado_t    estado_b;

    ascensor_ctrl_n #(.NUM_PISOS(10), .T_PUERTA(TP), .T_VIAJE(TV)) dut_a (
        .clk(clk), .reset(reset), .botones(botones_a), .boton_puertas(bp_a),
        .estado_puertas(ep_a), .cambio_piso(cp_a), .sensor_puertas(sp_a),
        .luces(luces_a), .display(display_a), .aviso(aviso_a),
        .puertas(puertas_a), .motor(motor_a), .estado(estado_a)
    );

    ascensor_ctrl_n #(.NUM_PISOS(4), .T_PUERTA(TP), .T_VIAJE(TV)) dut_b (
        .clk(clk), .reset(reset), .botones(botones_b), .boton_puertas(bp_b),
        .estado_puertas(ep_b), .cambio_piso(cp_b), .sensor_puertas(sp_b),
        .luces(luces_b), .display(display_b), .aviso(aviso_b),
        .puertas(puertas_b), .motor(motor_b), .estado(estado_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_a();
        cp_a = 1'b1; tick(); cp_a = 1'b0; tick();
    endtask

    task automatic pulse_b();
        cp_b = 1'b1; tick(); cp_b = 1'b0; tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        reset = 1'b0;
        botones_a = '0; bp_a = '0; ep_a = 2'b10; cp_a = 1'b0; sp_a = 1'b0;
        botones_b = '0; bp_b = '0; ep_b = 2'b10; cp_b = 1'b0; sp_b = 1'b0;
        #1;
        chk("rst_estado",  32'(estado_a),  32'(REPOSO));
        chk("rst_luces",   32'(luces_a),   0);
        chk("rst_display", 32'(display_a), 0);
        chk("rst_aviso",   32'(aviso_a),   0);
        chk("rst_puertas", 32'(puertas_a), 0);
        chk("rst_motor",   32'(motor_a),   0);
        tick(2);
        reset = 1'b1;
        tick(2);

        // Call floor 3 from floor 0
        botones_a[3] = 1'b1; tick(); botones_a[3] = 1'b0;
        chk("latch3_luces",  32'(luces_a),  'h008);
        chk("latch3_estado", 32'(estado_a), 32'(REPOSO));
        tick();
        chk("up_estado", 32'(estado_a), 32'(SUBIENDO));
        chk("up_motor",  32'(motor_a),  'h1);
        chk("up_aviso",  32'(aviso_a),  'h1);
        pulse_a();
        chk("floor1_display", 32'(display_a), 1);
        chk("floor1_motor",   32'(motor_a),   'h1);
        pulse_a(); pulse_a();
        chk("arr3_display", 32'(display_a), 3);
        chk("arr3_motor",   32'(motor_a),   0);
        chk("arr3_puertas", 32'(puertas_a), 'h1);
        chk("arr3_estado",  32'(estado_a),  32'(ABRIENDO));
        ep_a = 2'b01; tick();
        chk("open3_estado",  32'(estado_a),  32'(ABIERTA));
        chk("open3_puertas", 32'(puertas_a), 0);
        chk("open3_luces",   32'(luces_a),   0);

        // Obstruction holds the door open; release starts a full dwell
        sp_a = 1'b1; tick(100);
        chk("obst_estado", 32'(estado_a),   32'(ABIERTA));
        chk("obst_aviso2", 32'(aviso_a[2]), 1);
        sp_a = 1'b0;
        n = 0;
        while (estado_a != CERRANDO && n < 50) begin
            tick(); n++;
        end
        chk("dwell_cycles",  n,              TP + 1);
        chk("close_puertas", 32'(puertas_a), 'h2);
        chk("clear_aviso2",  32'(aviso_a[2]), 0);

        // Obstruction while closing reopens
        ep_a = 2'b00; tick();
        chk("closing_estado", 32'(estado_a), 32'(CERRANDO));
        sp_a = 1'b1; tick(); sp_a = 1'b0;
        chk("reopen_puertas", 32'(puertas_a), 'h1);
        chk("reopen_estado",  32'(estado_a),  32'(ABRIENDO));
        ep_a = 2'b01; tick();
        chk("reopened_estado", 32'(estado_a), 32'(ABIERTA));
        bp_a = 2'b10; tick(); bp_a = 2'b00;
        chk("btnclose_estado", 32'(estado_a), 32'(CERRANDO));
        ep_a = 2'b10; tick();
        chk("idle3_estado",  32'(estado_a),  32'(REPOSO));
        chk("idle3_display", 32'(display_a), 3);

        // Move to floor 5 and park
        botones_a[5] = 1'b1; tick(); botones_a[5] = 1'b0; tick();
        pulse_a(); pulse_a();
        chk("arr5_display", 32'(display_a), 5);
        chk("arr5_estado",  32'(estado_a),  32'(ABRIENDO));
        ep_a = 2'b01; tick();
        bp_a = 2'b10; tick(); bp_a = 2'b00;
        ep_a = 2'b10; tick();
        chk("idle5_estado", 32'(estado_a), 32'(REPOSO));

        // Calls above and below at once: up first, then down
        botones_a = 10'h104; tick(); botones_a = '0;
        chk("both_luces", 32'(luces_a), 'h104);
        tick();
        chk("both_estado", 32'(estado_a), 32'(SUBIENDO));
        chk("both_motor",  32'(motor_a),  'h1);
        repeat (3) pulse_a();
        chk("arr8_display", 32'(display_a), 8);
        chk("arr8_estado",  32'(estado_a),  32'(ABRIENDO));
        ep_a = 2'b01; tick();
        chk("open8_luces", 32'(luces_a), 'h004);
        bp_a = 2'b10; tick(); bp_a = 2'b00;
        ep_a = 2'b10; tick();
        chk("rev_estado", 32'(estado_a), 32'(BAJANDO));
        chk("rev_motor",  32'(motor_a),  'h2);
        chk("rev_aviso",  32'(aviso_a),  'h2);
        repeat (6) pulse_a();
        chk("arr2_display", 32'(display_a), 2);
        chk("arr2_estado",  32'(estado_a),  32'(ABRIENDO));
        chk("arr2_motor",   32'(motor_a),   0);
        ep_a = 2'b01; tick();
        chk("open2_luces", 32'(luces_a), 0);
        bp_a = 2'b10; tick(); bp_a = 2'b00;
        ep_a = 2'b10; tick();
        chk("idle2_estado", 32'(estado_a), 32'(REPOSO));

        // Four-floor build: stops at top floor, no wrap
        botones_b[3] = 1'b1; tick(); botones_b[3] = 1'b0; tick();
        chk("b_up_estado", 32'(estado_b), 32'(SUBIENDO));
        repeat (3) pulse_b();
        chk("b_top_display", 32'(display_b), 3);
        chk("b_top_motor",   32'(motor_b),   0);
        chk("b_top_estado",  32'(estado_b),  32'(ABRIENDO));
        pulse_b();
        chk("b_nowrap_display", 32'(display_b), 3);

        // Travel watchdog: no floor pulses while going up
        botones_a[6] = 1'b1; tick(); botones_a[6] = 1'b0; tick();
        chk("wd_up_estado", 32'(estado_a), 32'(SUBIENDO));
        n = 0;
        while (!aviso_a[3] && n < 200) begin
            tick(); n++;
        end
        chk("wd_cycles",  n,              TV + 1);
        chk("wd_estado",  32'(estado_a),  32'(FALLA));
        chk("wd_motor",   32'(motor_a),   0);
        chk("wd_puertas", 32'(puertas_a), 0);
        chk("wd_aviso",   32'(aviso_a),   'h8);
        cp_a = 1'b1; bp_a = 2'b01; botones_a = 10'h3ff; tick(3);
        cp_a = 1'b0; bp_a = 2'b00; botones_a = '0;
        chk("falla_hold_estado",  32'(estado_a),  32'(FALLA));
        chk("falla_hold_display", 32'(display_a), 2);
        chk("falla_hold_luces",   32'(luces_a),   'h040);

        // Asynchronous reset clears the fault
        reset = 1'b0; #1;
        chk("rst2_estado",  32'(estado_a),  32'(REPOSO));
        chk("rst2_aviso",   32'(aviso_a),   0);
        chk("rst2_luces",   32'(luces_a),   0);
        chk("rst2_display", 32'(display_a), 0);
        tick(2);

        // No state change on the first edge after reset release
        bp_a = 2'b01; reset = 1'b1;
        tick();
        chk("arm_first_edge", 32'(estado_a), 32'(REPOSO));
        tick();
        chk("arm_second_edge", 32'(estado_a), 32'(ABRIENDO));
        bp_a = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
